// File: rtl/alu_slice_sequencer.sv
// Sequencer that adds two WIDTH-bit operands by stepping an external 2-bit adder
// slice across them, two bits per clock. Define ALU_SEQ_ZERO_EN to build in the ZERO flag.
module alu_slice_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  input  logic             CIN,
  output logic [1:0]       SL_Y,
  output logic [1:0]       SL_DATA,
  output logic             SL_CIN,
  input  logic [1:0]       SL_SUM,
  input  logic             SL_COUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_cy;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;

  logic [WIDTH+1:0] w_acc_wide;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_in_run;
  logic             w_last;
  logic             w_finish;

  // The new slice sum enters at the top; slicing the widened word also works for WIDTH == 2.
  assign w_acc_wide = {SL_SUM, r_acc};
  assign w_acc_next = w_acc_wide[WIDTH+1:2];
  assign w_in_run   = (r_state == S_RUN);
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_finish   = w_in_run && !ABORT && w_last;

  assign SL_Y    = w_in_run ? r_a_sh[1:0] : 2'b00;
  assign SL_DATA = w_in_run ? r_b_sh[1:0] : 2'b00;
  assign SL_CIN  = w_in_run ? r_cy : 1'b0;

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign RESULT = r_result;
  assign CARRY  = r_carry;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_cy     <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_a_sh  <= OP_A;
            r_b_sh  <= OP_B;
            r_cy    <= CIN;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort wins even on the final step: no DONE and the published result is kept.
          if (ABORT) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_a_sh <= r_a_sh >> 2;
            r_b_sh <= r_b_sh >> 2;
            r_acc  <= w_acc_next;
            r_cy   <= SL_COUT;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= w_acc_next;
              r_carry  <= SL_COUT;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_EN
  logic r_zero;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_zero <= 1'b0;
    end else if (w_finish) begin
      r_zero <= (w_acc_next == '0);
    end
  end

  assign ZERO = r_zero;
`else
  assign ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Self-checking bench for alu_slice_sequencer (WIDTH=4) with a behavioural 2-bit adder slice.
module tb_alu_slice_sequencer;

  localparam int WIDTH = 4;
  localparam int N     = WIDTH / 2;

`ifdef ALU_SEQ_ZERO_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic [1:0]       sl_y;
  logic [1:0]       sl_data;
  logic             sl_cin;
  logic [1:0]       sl_sum;
  logic             sl_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  always #5 clk = ~clk;

  // Behavioural 2-bit full-adder slice.
  assign {sl_cout, sl_sum} = {1'b0, sl_y} + {1'b0, sl_data} + {2'b00, sl_cin};

  alu_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .CLK     (clk),
    .RST     (rst),
    .START   (start),
    .ABORT   (abort),
    .OP_A    (op_a),
    .OP_B    (op_b),
    .CIN     (cin),
    .SL_Y    (sl_y),
    .SL_DATA (sl_data),
    .SL_CIN  (sl_cin),
    .SL_SUM  (sl_sum),
    .SL_COUT (sl_cout),
    .BUSY    (busy),
    .DONE    (done),
    .RESULT  (result),
    .CARRY   (carry),
    .ZERO    (zero)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] res;
    logic             cy;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             z;
  } exp_t;

  vec_t vecs[7];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [1:0] log_y[8];
  logic [1:0] log_d[8];
  logic       log_c[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"},    32'(busy),    0);
    check({name, " done"},    32'(done),    0);
    check({name, " result"},  32'(result),  0);
    check({name, " carry"},   32'(carry),   0);
    check({name, " zero"},    32'(zero),    0);
    check({name, " sl_y"},    32'(sl_y),    0);
    check({name, " sl_data"}, 32'(sl_data), 0);
    check({name, " sl_cin"},  32'(sl_cin),  0);
  endtask

  // Entered at the negedge right after the accepting edge; runs until DONE or a cycle budget.
  task automatic wait_done(input string name, input int exp_busy);
    int   cyc = 0;
    int   nb  = 0;
    exp_t e;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) begin
        if (nb < 8) begin
          log_y[nb] = sl_y;
          log_d[nb] = sl_data;
          log_c[nb] = sl_cin;
        end
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
    check({name, " done seen"}, 32'(done), 1);
    if (done === 1'b1) begin
      check({name, " busy during done"}, 32'(busy), 0);
      check({name, " busy cycles"}, 32'(nb), 32'(exp_busy));
      check({name, " sb nonempty"}, 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({name, " result"}, 32'(result), 32'(e.res));
        check({name, " carry"},  32'(carry),  32'(e.cy));
        check({name, " zero"},   32'(zero),   32'(e.z));
      end
      @(negedge clk);
      check({name, " done one pulse"}, 32'(done), 0);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] res, input logic cy);
    exp_t e;
    e.res = res;
    e.cy  = cy;
    e.z   = ZEN && (res == '0);
    sb_q.push_back(e);
  endtask

  task automatic do_add(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH-1:0] res, input logic cy);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    push_exp(res, cy);
    @(negedge clk);
    start = 1'b0;
    wait_done(name, N);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 4'h5, b: 4'h3, c: 1'b0, res: 4'h8, cy: 1'b0};
    vecs[1] = '{a: 4'hF, b: 4'h1, c: 1'b0, res: 4'h0, cy: 1'b1};
    vecs[2] = '{a: 4'h7, b: 4'h8, c: 1'b1, res: 4'h0, cy: 1'b1};
    vecs[3] = '{a: 4'h2, b: 4'h2, c: 1'b1, res: 4'h5, cy: 1'b0};
    vecs[4] = '{a: 4'hA, b: 4'h5, c: 1'b0, res: 4'hF, cy: 1'b0};
    vecs[5] = '{a: 4'h9, b: 4'h6, c: 1'b1, res: 4'h0, cy: 1'b1};
    vecs[6] = '{a: 4'hE, b: 4'hD, c: 1'b1, res: 4'hC, cy: 1'b1};

    // Reset with random inputs.
    rst   = 1'b1;
    start = 1'($urandom);
    abort = 1'($urandom);
    op_a  = WIDTH'($urandom);
    op_b  = WIDTH'($urandom);
    cin   = 1'($urandom);
    #2;
    check_all_zero("reset async");
    repeat (2) @(negedge clk);
    check_all_zero("reset held");
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle busy",   32'(busy),   0);
      check("idle done",   32'(done),   0);
      check("idle result", 32'(result), 0);
    end
    check_all_zero("idle after reset");

    // Table-driven additions, back to back at full throughput.
    for (int i = 0; i < 7; i++) begin
      do_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].res, vecs[i].cy);
      if (i == 0) begin
        check("slice step0 y",   32'(log_y[0]), 32'h1);
        check("slice step0 d",   32'(log_d[0]), 32'h3);
        check("slice step0 cin", 32'(log_c[0]), 32'h0);
        check("slice step1 y",   32'(log_y[1]), 32'h1);
        check("slice step1 d",   32'(log_d[1]), 32'h0);
        check("slice step1 cin", 32'(log_c[1]), 32'h1);
      end
    end

    // START during RUN is ignored.
    op_a  = 4'h5;
    op_b  = 4'h3;
    cin   = 1'b0;
    start = 1'b1;
    push_exp(4'h8, 1'b0);
    @(negedge clk);
    op_a = 4'hF;
    op_b = 4'hF;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored start", 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ignored start no 2nd done", 32'(done), 0);
      check("ignored start no 2nd busy", 32'(busy), 0);
    end

    // ABORT in the first RUN cycle.
    op_a  = 4'h1;
    op_b  = 4'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort1 busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort1 no done", 32'(done), 0);
    end
    check("abort1 result kept", 32'(result), 32'h8);
    check("abort1 carry kept",  32'(carry),  0);
    check("abort1 zero kept",   32'(zero),   0);

    // ABORT on the final step beats completion.
    op_a  = 4'h2;
    op_b  = 4'h3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort2 done", 32'(done), 0);
    check("abort2 busy", 32'(busy), 0);
    @(negedge clk);
    check("abort2 no late done", 32'(done), 0);
    check("abort2 result kept", 32'(result), 32'h8);

    // Reset in the middle of RUN, then a clean addition.
    op_a  = 4'h5;
    op_b  = 4'h4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrst pre busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst no done", 32'(done), 0);
    do_add("post reset", 4'h6, 4'h7, 1'b0, 4'hD, 1'b0);

    check("scoreboard drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
